// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch front end for the decode/execute stage. It streams 16-bit words out of
// a synchronous block-RAM read port, pairs consecutive words into
// instructions, buffers them in a small queue, and presents the queue head to
// decode through a valid/ready handshake. Decode can restart fetch at any
// address with a redirect.
//
// Instruction format: word0 = {op[7:0], regnum[7:0]}, word1 = address/number.
//
// Ports
//   clkb             clock, shared with the RAM read port
//   rst              asynchronous reset, active high
//   enb, addrb       RAM read enable / word address
//   dob              RAM read data (registered inside the RAM)
//   redirect_valid   flush the queue and restart fetch at redirect_addr
//   redirect_addr    new fetch address
//   inst_valid       queue head holds a complete instruction
//   inst_ready       decode accepts the head
//   inst_op          head opcode      (word0[15:8])
//   inst_regnum      head register    (word0[7:0])
//   inst_address_num head operand     (word1)
//   inst_pc          address of the head instruction's word0
//
// Optional build macro FETCH_PERF_EN adds two saturating 16-bit counters:
//   stall_cycles     cycles with inst_valid && !inst_ready
//   flush_count      sampled redirect_valid pulses
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clkb,
  input  logic              rst,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [15:0]       dob,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        inst_op,
  output logic [7:0]        inst_regnum,
  output logic [15:0]       inst_address_num,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam int               CNT_W    = IDX_W + 1;
  localparam int               OCC_W    = CNT_W + 2;
  localparam logic [OCC_W-1:0] WORD_CAP = OCC_W'(2 * DEPTH);

  typedef struct packed {
    logic [15:0]       word0;
    logic [15:0]       word1;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  // Fetch and return-path state. Stage 0 of the in-flight tracker is enb
  // itself (plus its epoch tag); stage 1 also carries the word's address.
  logic              started;
  logic              epoch;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fl0_epoch;
  logic              fl1_valid;
  logic              fl1_epoch;
  logic [ADDR_W-1:0] fl1_pc;

  // Assembly: phase 1 means word0 is parked in the holding register.
  logic              phase;
  logic [15:0]       w0_data;
  logic [ADDR_W-1:0] w0_pc;

  // Shift-register queue: entry 0 is always the head, so the inst_* outputs
  // come straight from flops and keep their last value once the queue drains.
  entry_t            fifo [DEPTH];
  logic [CNT_W-1:0]  count;

  logic              do_redirect;
  logic [ADDR_W-1:0] target;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              capture;
  logic              enqueue;
  logic              pop;
  logic [IDX_W-1:0]  wr_idx;

  // NOTE: every signal gets a value on every path through always_comb;
  // a missing assignment on any path would infer a latch.
  always_comb begin
    // The first edge after reset acts as a redirect to RESET_PC.
    do_redirect = redirect_valid || !started;
    target      = redirect_valid ? redirect_addr : RESET_PC;
    // Words already owned by the front end: queued pairs, a parked word0 and
    // both in-flight stages. Old-epoch words still count until they retire.
    occupancy   = OCC_W'({count, 1'b0}) + OCC_W'(phase) + OCC_W'(enb) + OCC_W'(fl1_valid);
    issue       = occupancy < WORD_CAP;
    capture     = fl1_valid && (fl1_epoch == epoch);
    enqueue     = capture && phase;
    pop         = inst_valid && inst_ready;
    wr_idx      = pop ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      epoch     <= 1'b0;
      fetch_pc  <= RESET_PC;
      enb       <= 1'b0;
      addrb     <= RESET_PC;
      fl0_epoch <= 1'b0;
      fl1_valid <= 1'b0;
      fl1_epoch <= 1'b0;
      fl1_pc    <= '0;
      phase     <= 1'b0;
      w0_data   <= '0;
      w0_pc     <= '0;
      count     <= '0;
      // NOTE: the queue array is reset because entry 0 drives the outputs
      // directly and they must read zero while rst is held.
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      started   <= 1'b1;
      fl1_valid <= enb;
      fl1_epoch <= fl0_epoch;
      fl1_pc    <= addrb;

      if (do_redirect) begin
        // New epoch: anything still in flight is dropped on return.
        epoch     <= ~epoch;
        enb       <= 1'b1;
        addrb     <= target;
        fetch_pc  <= target + 1'b1;
        fl0_epoch <= ~epoch;
        phase     <= 1'b0;
        count     <= '0;
      end else begin
        enb <= issue;
        if (issue) begin
          addrb     <= fetch_pc;
          fetch_pc  <= fetch_pc + 1'b1;
          fl0_epoch <= epoch;
        end

        if (capture) begin
          phase <= ~phase;
          if (!phase) begin
            w0_data <= dob;
            w0_pc   <= fl1_pc;
          end
        end

        // Keep the head in place when the last entry leaves.
        if (pop && count > CNT_W'(1)) begin
          for (int i = 0; i < DEPTH - 1; i++) fifo[i] <= fifo[i + 1];
        end
        if (enqueue) begin
          fifo[wr_idx] <= '{word0: w0_data, word1: dob, pc: w0_pc};
        end
        count <= count + CNT_W'(enqueue) - CNT_W'(pop);
      end
    end
  end

  assign inst_valid       = (count != '0);
  assign inst_op          = fifo[0].word0[15:8];
  assign inst_regnum      = fifo[0].word0[7:0];
  assign inst_address_num = fifo[0].word1;
  assign inst_pc          = fifo[0].pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clkb or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (inst_valid && !inst_ready && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (redirect_valid && flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Bench for instr_fetch_queue with a behavioural block-RAM on the read port.
// Expected instructions are derived from the bench's own memory image and
// queued whenever fetch is (re)started; they are popped and compared on every
// accepted handshake. Cycle-exact checks cover reset, back-pressure, redirect
// latency, address wrap, epoch dropping and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [7:0]        op;
    logic [7:0]        regnum;
    logic [15:0]       num;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic              clkb = 1'b0;
  logic              rst;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [15:0]       dob = '0;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [7:0]        inst_op;
  logic [7:0]        inst_regnum;
  logic [15:0]       inst_address_num;
  logic [ADDR_W-1:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]       stall_cycles;
  logic [15:0]       flush_count;
`endif

  logic [15:0] mem [0:(1 << ADDR_W) - 1];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clkb = ~clkb;

  // Synchronous RAM read port: data registered on the edge where enb=1.
  always @(posedge clkb) if (enb) dob <= mem[addrb];

  instr_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clkb             (clkb),
    .rst              (rst),
    .enb              (enb),
    .addrb            (addrb),
    .dob              (dob),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_op          (inst_op),
    .inst_regnum      (inst_regnum),
    .inst_address_num (inst_address_num),
    .inst_pc          (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  // Queue the next n instructions expected from a fetch starting at start.
  task automatic push_stream(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] a1;
    exp_t              e;
    a = start;
    for (int i = 0; i < n; i++) begin
      a1       = a + 1'b1;
      e.op     = mem[a][15:8];
      e.regnum = mem[a][7:0];
      e.num    = mem[a1];
      e.pc     = a;
      sb.push_back(e);
      a = a1 + 1'b1;
    end
  endtask

  // One clock: at the falling edge, score any handshake that the coming
  // rising edge will accept, then advance to just after the rising edge.
  // Handshakes coinciding with a redirect belong to the abandoned stream.
  task automatic cycle();
    exp_t e;
    @(negedge clkb);
    if (!rst && inst_valid && inst_ready && !redirect_valid && sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({inst_op, inst_regnum, inst_address_num, inst_pc} !== {e.op, e.regnum, e.num, e.pc}) begin
        errors++;
        $display("FAIL sb_inst: got op=%h reg=%h num=%h pc=%h, expected op=%h reg=%h num=%h pc=%h",
                 inst_op, inst_regnum, inst_address_num, inst_pc, e.op, e.regnum, e.num, e.pc);
      end
    end
    @(posedge clkb);
    #1;
  endtask

  // Run until every queued expectation has been delivered, within budget.
  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d instructions outstanding after %0d cycles, expected 0",
               name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clkb);
    #1;
    checks++; if (enb !== 1'b0) begin errors++; $display("FAIL rst_enb: got %b, expected 0", enb); end
    checks++; if (addrb !== '0) begin errors++; $display("FAIL rst_addrb: got %h, expected 000", addrb); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", inst_valid); end
    checks++;
    if ({inst_op, inst_regnum, inst_address_num, inst_pc} !== '0) begin
      errors++;
      $display("FAIL rst_head: got op=%h reg=%h num=%h pc=%h, expected all zero",
               inst_op, inst_regnum, inst_address_num, inst_pc);
    end
    rst = 1'b0;
    sb.delete();
    push_stream('0, 4);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (inst_valid !== (k == 4)) begin
        errors++;
        $display("FAIL rst_valid_edge%0d: got %b, expected %b", k, inst_valid, (k == 4));
      end
    end
    checks++;
    if ({inst_op, inst_regnum, inst_address_num, inst_pc} !== {8'h04, 8'h01, 16'h1234, 10'h000}) begin
      errors++;
      $display("FAIL rst_first_inst: got op=%h reg=%h num=%h pc=%h, expected op=04 reg=01 num=1234 pc=000",
               inst_op, inst_regnum, inst_address_num, inst_pc);
    end
    // Four instructions back to back at one per two cycles.
    wait_drain("rst_stream", 7);
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] exp_addr;
    rst = 1'b1;
    inst_ready = 1'b0;
    @(posedge clkb);
    #1;
    rst = 1'b0;
    sb.delete();
    push_stream('0, 4);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp_addr = (k <= 8) ? ADDR_W'(k - 1) : ADDR_W'(7);
      checks++;
      if (enb !== (k <= 8)) begin errors++; $display("FAIL bp_enb_edge%0d: got %b, expected %b", k, enb, (k <= 8)); end
      checks++;
      if (addrb !== exp_addr) begin errors++; $display("FAIL bp_addrb_edge%0d: got %h, expected %h", k, addrb, exp_addr); end
      if (k >= 5) begin
        checks++;
        if ({inst_valid, inst_pc, inst_op} !== {1'b1, 10'h000, 8'h04}) begin
          errors++;
          $display("FAIL bp_head_edge%0d: got valid=%b pc=%h op=%h, expected valid=1 pc=000 op=04",
                   k, inst_valid, inst_pc, inst_op);
        end
      end
    end
    inst_ready = 1'b1;
    cycle();
    checks++;
    if ({enb, addrb} !== {1'b0, 10'h007}) begin
      errors++;
      $display("FAIL bp_hold: got enb=%b addrb=%h, expected enb=0 addrb=007", enb, addrb);
    end
    cycle();
    checks++;
    if ({enb, addrb} !== {1'b1, 10'h008}) begin
      errors++;
      $display("FAIL bp_resume: got enb=%b addrb=%h, expected enb=1 addrb=008", enb, addrb);
    end
    // Remaining pcs 4 and 6 on the next two consecutive cycles.
    wait_drain("bp_release", 2);
  endtask

  task automatic test_redirect_full();
    inst_ready = 1'b0;
    repeat (12) cycle();
    checks++;
    if ({inst_valid, enb} !== 2'b10) begin
      errors++;
      $display("FAIL full_state: got valid=%b enb=%b, expected valid=1 enb=0", inst_valid, enb);
    end
    redirect_valid = 1'b1;
    redirect_addr  = 10'h100;
    inst_ready     = 1'b1;
    sb.delete();
    push_stream(10'h100, 2);
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if ({inst_valid, enb, addrb} !== {1'b0, 1'b1, 10'h100}) begin
      errors++;
      $display("FAIL redir_issue: got valid=%b enb=%b addrb=%h, expected valid=0 enb=1 addrb=100",
               inst_valid, enb, addrb);
    end
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (inst_valid !== (k == 3)) begin
        errors++;
        $display("FAIL redir_valid_e%0d: got %b, expected %b", k, inst_valid, (k == 3));
      end
    end
    checks++;
    if (inst_pc !== 10'h100) begin errors++; $display("FAIL redir_pc: got %h, expected 100", inst_pc); end
    wait_drain("redir_full", 4);
  endtask

  task automatic test_wrap();
    mem[10'h3FE] = 16'h0502;
    mem[10'h3FF] = 16'h0007;
    mem[10'h000] = 16'h0100;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 10'h3FE;
    sb.delete();
    push_stream(10'h3FE, 3);
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({inst_valid, inst_pc, inst_op, inst_address_num} !== {1'b1, 10'h3FE, 8'h05, 16'h0007}) begin
      errors++;
      $display("FAIL wrap_head: got valid=%b pc=%h op=%h num=%h, expected valid=1 pc=3fe op=05 num=0007",
               inst_valid, inst_pc, inst_op, inst_address_num);
    end
    wait_drain("wrap_3fe", 6);
    // Wrap between word0 and word1 of a single instruction.
    redirect_valid = 1'b1;
    redirect_addr  = 10'h3FF;
    push_stream(10'h3FF, 2);
    cycle();
    redirect_valid = 1'b0;
    wait_drain("wrap_3ff", 8);
  endtask

  task automatic test_epoch();
    inst_ready = 1'b1;
    checks++;
    if (enb !== 1'b1) begin errors++; $display("FAIL epoch_inflight: got enb=%b, expected 1", enb); end
    redirect_valid = 1'b1;
    redirect_addr  = 10'h011;
    sb.delete();
    push_stream(10'h011, 3);
    cycle();
    redirect_valid = 1'b0;
    // Two stale words return during the next two edges and must vanish.
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (inst_valid !== (k == 3)) begin
        errors++;
        $display("FAIL epoch_valid_e%0d: got %b, expected %b", k, inst_valid, (k == 3));
      end
    end
    checks++;
    if (inst_pc !== 10'h011) begin errors++; $display("FAIL epoch_pc: got %h, expected 011", inst_pc); end
    wait_drain("epoch", 6);
  endtask

  task automatic test_back_to_back();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 10'h200;
    sb.delete();
    cycle();
    redirect_addr = 10'h020;
    push_stream(10'h020, 2);
    cycle();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (inst_valid !== (k == 3)) begin
        errors++;
        $display("FAIL b2b_valid_e%0d: got %b, expected %b", k, inst_valid, (k == 3));
      end
    end
    checks++;
    if (inst_pc !== 10'h020) begin errors++; $display("FAIL b2b_pc: got %h, expected 020", inst_pc); end
    wait_drain("b2b", 4);
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b1;
    @(negedge clkb);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (enb !== 1'b0) begin errors++; $display("FAIL arst_enb: got %b, expected 0", enb); end
    checks++; if (addrb !== '0) begin errors++; $display("FAIL arst_addrb: got %h, expected 000", addrb); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, expected 0", inst_valid); end
    checks++;
    if ({inst_op, inst_regnum, inst_address_num, inst_pc} !== '0) begin
      errors++;
      $display("FAIL arst_head: got op=%h reg=%h num=%h pc=%h, expected all zero",
               inst_op, inst_regnum, inst_address_num, inst_pc);
    end
    mem[10'h000] = 16'h0401;
    @(posedge clkb);
    #1;
    rst = 1'b0;
    sb.delete();
    push_stream('0, 2);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (inst_valid !== (k == 4)) begin
        errors++;
        $display("FAIL arst_valid_edge%0d: got %b, expected %b", k, inst_valid, (k == 4));
      end
    end
    wait_drain("arst_stream", 4);
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    inst_ready = 1'b0;
    @(posedge clkb);
    #1;
    checks++;
    if ({stall_cycles, flush_count} !== 32'h0) begin
      errors++;
      $display("FAIL perf_rst: got stall=%0d flush=%0d, expected 0 0", stall_cycles, flush_count);
    end
    rst = 1'b0;
    sb.delete();
    repeat (4) cycle();
    repeat (10) cycle();
    checks++;
    if (stall_cycles !== 16'd10) begin errors++; $display("FAIL perf_stall: got %0d, expected 10", stall_cycles); end
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 10'h040;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if ({stall_cycles, flush_count} !== {16'd10, 16'd1}) begin
      errors++;
      $display("FAIL perf_flush: got stall=%0d flush=%0d, expected 10 1", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'((i * 40503) ^ 16'h5A3C);
    mem[0] = 16'h0401;
    mem[1] = 16'h1234;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b1;

    test_reset();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_epoch();
    test_back_to_back();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch front end that sits directly upstream of the decode/execute stage. It drives the 16-bit block-RAM read port (enb/addrb/dob), pairs consecutive words into instructions, buffers them in a small queue, and hands them to decode with a valid/ready handshake.
- Instruction format: word0 = {op[7:0], regnum[7:0]}; word1 = 16-bit address/number.
- Decode redirects fetch on jumps and loop-backs.

Parameters:
ADDR_W, 10, RAM word-address width; the PC wraps modulo 2^ADDR_W.
DEPTH, 4, instruction queue entries; power of two, minimum 2.
RESET_PC, 0, fetch start address after reset.

Ports:
clkb  in  1  clock; also the RAM read-port clock.
rst  in  1  asynchronous reset, active-high.
enb  out  1  RAM read enable.
addrb  out  ADDR_W  RAM read address.
dob  in  16  RAM read data; registered by the RAM on the edge where enb=1.
redirect_valid  in  1  flush the queue and restart fetch.
redirect_addr  in  ADDR_W  new fetch address.
inst_valid  out  1  queue head holds a complete instruction.
inst_ready  in  1  decode accepts the head.
inst_op  out  8  head opcode (word0[15:8]).
inst_regnum  out  8  head register number (word0[7:0]).
inst_address_num  out  16  head operand (word1).
inst_pc  out  ADDR_W  address of the head instruction's word0.

Behaviour:
- Reset (asynchronous, while rst=1):
  - enb=0, addrb=RESET_PC, inst_valid=0, inst_op/regnum/address_num=0, inst_pc=0.
  - Queue emptied; in-flight tracking cleared; word phase = 0.
  - fetch_pc=RESET_PC.
- Issue:
  - On each posedge, if (queued words + in-flight words) < 2*DEPTH: enb<=1, addrb<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps).
  - Otherwise enb<=0 and addrb holds its value.
  - Maximum of one outstanding word per cycle.
- Return path:
  - A word issued with enb at edge E is latched by the RAM at E+1 and captured from dob at E+2.
  - An in-flight shift register (2 stages) tags each word with the current epoch bit.
- Assembly:
  - phase 0: the captured word goes to the word0 holding register together with its PC.
  - phase 1: {word0, word1, pc} is written to the queue tail.
  - Word pairing is by arrival order only. Odd redirect addresses are legal; no alignment check.
- Output:
  - The queue head drives the inst_* outputs directly from flops.
  - The head stays stable while inst_valid && !inst_ready.
  - Pop when inst_valid && inst_ready.
  - Enqueue and pop in the same cycle are legal when full; occupancy is unchanged.
- Throughput: one instruction per 2 cycles (RAM bound). With inst_ready held high there are no bubbles beyond that.
- Redirect (sampled at edge E):
  - Queue cleared and phase reset to 0.
  - Epoch toggled; returning words with the old epoch are dropped.
  - addrb<=redirect_addr, enb<=1, fetch_pc<=redirect_addr+1.
  - A pop handshake in the same cycle counts as consumed.
  - Redirect has priority over issue and over enqueue in that cycle.
  - First inst_valid appears after edge E+3.
- Reset release: the first edge behaves as a redirect to RESET_PC, so inst_valid first rises after the 4th posedge.
- Wrap: address 2^ADDR_W-1 is followed by address 0, including inside one instruction. inst_pc is the word0 address.
- Empty: inst_valid=0. Outputs hold their last popped values; decode must not rely on them.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output stall_cycles[15:0] and output flush_count[15:0].
  - stall_cycles increments on every cycle with inst_valid && !inst_ready.
  - flush_count increments on each sampled redirect_valid.
  - Both saturate at 0xFFFF and clear on rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset with mem[0]=0x0401, mem[1]=0x1234, inst_ready=1 -> inst_valid rises after the 4th edge post-release; op=0x04, regnum=0x01, address_num=0x1234, pc=0.
2. inst_ready=0 from release, DEPTH=4 -> enb issues addresses 0..7, then enb=0 and addrb holds 7; the head is stable at pc=0. Raising inst_ready -> pcs 0,2,4,6 delivered on consecutive cycles, then fetch resumes at 8.
3. Queue full, redirect_valid with redirect_addr=0x100 -> no stale instruction appears; next inst_valid is after E+3 with pc=0x100, op/num from mem[0x100]/mem[0x101].
4. Redirect to 0x3FE, mem[0x3FE]=0x0502, mem[0x3FF]=0x0007, mem[0]=0x0100 -> instruction pc=0x3FE with num 0x0007, then the next instruction at pc=0x000.
5. Redirect to 0x011 while two words are in flight; inject an old-epoch word -> it is discarded; the first instruction has pc=0x011 and pairs mem[0x11]/mem[0x12].
6. rst asserted mid-fetch -> all outputs go to 0 immediately without a clock; after release the sequence matches scenario 1. With FETCH_PERF_EN, 10 stalled cycles -> stall_cycles=10, and one redirect -> flush_count=1.
